// File: rtl/qos_pkt_wr_ctrl_if.sv
// Bundles the beat input stream, both class RAM write ports, reader pointers and status outputs
// of qos_pkt_wr_ctrl; master drives beats and read pointers, slave is the controller.
interface qos_pkt_wr_ctrl_if #(
    parameter int DW  = 8,
    parameter int IDW = 3,
    parameter int AW  = 11
);
    localparam int W = DW + IDW + 2;

    logic           in_vld;
    logic [DW-1:0]  in_data;
    logic           in_sop;
    logic           in_eop;
    logic           in_qos;
    logic [IDW-1:0] in_id;

    logic           hram_wen;
    logic           lram_wen;
    logic [AW-1:0]  hram_waddr;
    logic [AW-1:0]  lram_waddr;
    logic [W-1:0]   hram_wdata;
    logic [W-1:0]   lram_wdata;
    logic [AW-1:0]  hram_raddr;
    logic [AW-1:0]  lram_raddr;

    logic [AW-1:0]  h_commit_ptr;
    logic [AW-1:0]  l_commit_ptr;
    logic           pkt_done;
    logic           pkt_done_qos;
    logic           pkt_err;
    logic [15:0]    h_drop_cnt;
    logic [15:0]    l_drop_cnt;

    modport master (
        output in_vld, in_data, in_sop, in_eop, in_qos, in_id, hram_raddr, lram_raddr,
        input  hram_wen, lram_wen, hram_waddr, lram_waddr, hram_wdata, lram_wdata,
        input  h_commit_ptr, l_commit_ptr, pkt_done, pkt_done_qos, pkt_err,
        input  h_drop_cnt, l_drop_cnt
    );

    modport slave (
        input  in_vld, in_data, in_sop, in_eop, in_qos, in_id, hram_raddr, lram_raddr,
        output hram_wen, lram_wen, hram_waddr, lram_waddr, hram_wdata, lram_wdata,
        output h_commit_ptr, l_commit_ptr, pkt_done, pkt_done_qos, pkt_err,
        output h_drop_cnt, l_drop_cnt
    );
endinterface

// File: rtl/qos_pkt_wr_ctrl.sv
// Two-class packet write controller: writes beats into per-class circular RAMs, commits whole
// packets and rolls back aborted ones. Define QPWC_DROP_CNT_EN to enable the per-class abort counters.
module qos_pkt_wr_ctrl #(
    parameter int DW      = 8,
    parameter int IDW     = 3,
    parameter int AW      = 11,
    parameter int DEPTH   = 1144,
    parameter int MAX_LEN = 127
) (
    input logic              clk,
    input logic              rst_n,
    qos_pkt_wr_ctrl_if.slave bus
);
    localparam int W  = DW + IDW + 2;
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, RCV, DROP} state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic           curQos_q, curQos_d;
    logic [IDW-1:0] curId_q, curId_d;
    logic [AW-1:0]  hWptr_q, hWptr_d, lWptr_q, lWptr_d;
    logic [AW-1:0]  hCptr_q, hCptr_d, lCptr_q, lCptr_d;
    logic           done_q, doneQos_q, err_q;

    logic           vld_q, sop_q, eop_q, qos_q;
    logic [DW-1:0]  data_q;
    logic [IDW-1:0] id_q;
    logic [AW-1:0]  hRaddr_q, lRaddr_q;

    logic           wrEn, commit, abortH, abortL;
    logic           restartAbort, beatQos, full;
    logic [IDW-1:0] beatId;
    logic [AW-1:0]  hBase, lBase, baseAddr, nextAddr;

    // Reader pointers are registered with the beat so the full check sees no raw input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            qos_q    <= 1'b0;
            data_q   <= '0;
            id_q     <= '0;
            hRaddr_q <= '0;
            lRaddr_q <= '0;
        end else begin
            vld_q    <= bus.in_vld;
            sop_q    <= bus.in_sop;
            eop_q    <= bus.in_eop;
            qos_q    <= bus.in_qos;
            data_q   <= bus.in_data;
            id_q     <= bus.in_id;
            hRaddr_q <= bus.hram_raddr;
            lRaddr_q <= bus.lram_raddr;
        end
    end

    assign restartAbort = vld_q && sop_q && (state_q == RCV);
    assign beatQos      = sop_q ? qos_q : curQos_q;
    assign beatId       = sop_q ? id_q  : curId_q;

    // A restart in the same class writes its header where the aborted packet began.
    assign hBase    = (restartAbort && curQos_q)  ? hCptr_q : hWptr_q;
    assign lBase    = (restartAbort && !curQos_q) ? lCptr_q : lWptr_q;
    assign baseAddr = beatQos ? hBase : lBase;
    assign nextAddr = (baseAddr == AW'(DEPTH - 1)) ? '0 : baseAddr + AW'(1);
    assign full     = (nextAddr == (beatQos ? hRaddr_q : lRaddr_q));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        curQos_d = curQos_q;
        curId_d  = curId_q;
        hWptr_d  = hWptr_q;
        lWptr_d  = lWptr_q;
        hCptr_d  = hCptr_q;
        lCptr_d  = lCptr_q;
        wrEn     = 1'b0;
        commit   = 1'b0;
        abortH   = 1'b0;
        abortL   = 1'b0;

        if (vld_q) begin
            if (sop_q) begin
                if (restartAbort) begin
                    abortH = curQos_q;
                    abortL = !curQos_q;
                end
                if (full) begin
                    abortH  = abortH | beatQos;
                    abortL  = abortL | !beatQos;
                    state_d = eop_q ? IDLE : DROP;
                    len_d   = '0;
                end else begin
                    wrEn     = 1'b1;
                    curQos_d = qos_q;
                    curId_d  = id_q;
                    commit   = eop_q;
                    state_d  = eop_q ? IDLE : RCV;
                    len_d    = eop_q ? '0 : LW'(1);
                end
            end else begin
                case (state_q)
                    RCV: begin
                        if (eop_q) begin
                            state_d = IDLE;
                            len_d   = '0;
                            if (full) begin
                                abortH = beatQos;
                                abortL = !beatQos;
                            end else begin
                                wrEn   = 1'b1;
                                commit = 1'b1;
                            end
                        end else if ((len_q == LW'(MAX_LEN)) || full) begin
                            abortH  = beatQos;
                            abortL  = !beatQos;
                            state_d = DROP;
                            len_d   = '0;
                        end else begin
                            wrEn  = 1'b1;
                            len_d = len_q + LW'(1);
                        end
                    end
                    DROP: begin
                        if (eop_q) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end

        // Rollback first, so a same-cycle write to the same class overrides it.
        if (abortH) hWptr_d = hCptr_q;
        if (abortL) lWptr_d = lCptr_q;
        if (wrEn) begin
            if (beatQos) begin
                hWptr_d = nextAddr;
                if (commit) hCptr_d = nextAddr;
            end else begin
                lWptr_d = nextAddr;
                if (commit) lCptr_d = nextAddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            curQos_q  <= 1'b0;
            curId_q   <= '0;
            hWptr_q   <= '0;
            lWptr_q   <= '0;
            hCptr_q   <= '0;
            lCptr_q   <= '0;
            done_q    <= 1'b0;
            doneQos_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            curQos_q  <= curQos_d;
            curId_q   <= curId_d;
            hWptr_q   <= hWptr_d;
            lWptr_q   <= lWptr_d;
            hCptr_q   <= hCptr_d;
            lCptr_q   <= lCptr_d;
            done_q    <= commit;
            doneQos_q <= commit & beatQos;
            err_q     <= abortH | abortL;
        end
    end

    assign bus.hram_wen     = wrEn & beatQos;
    assign bus.lram_wen     = wrEn & ~beatQos;
    assign bus.hram_waddr   = hBase;
    assign bus.lram_waddr   = lBase;
    assign bus.hram_wdata   = wrEn ? {sop_q, eop_q, beatId, data_q} : '0;
    assign bus.lram_wdata   = wrEn ? {sop_q, eop_q, beatId, data_q} : '0;
    assign bus.h_commit_ptr = hCptr_q;
    assign bus.l_commit_ptr = lCptr_q;
    assign bus.pkt_done     = done_q;
    assign bus.pkt_done_qos = doneQos_q;
    assign bus.pkt_err      = err_q;

`ifdef QPWC_DROP_CNT_EN
    logic [15:0] hDrop_q, lDrop_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hDrop_q <= '0;
            lDrop_q <= '0;
        end else begin
            if (abortH && (hDrop_q != 16'hFFFF)) hDrop_q <= hDrop_q + 16'd1;
            if (abortL && (lDrop_q != 16'hFFFF)) lDrop_q <= lDrop_q + 16'd1;
        end
    end

    assign bus.h_drop_cnt = hDrop_q;
    assign bus.l_drop_cnt = lDrop_q;
`else
    assign bus.h_drop_cnt = '0;
    assign bus.l_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_qos_pkt_wr_ctrl.sv
// Scoreboard bench for qos_pkt_wr_ctrl: a packet-level model queues expected RAM writes and
// commit/abort events; a negedge monitor pops and compares them as the DUT presents them.
module tb_qos_pkt_wr_ctrl;
    localparam int DW      = 8;
    localparam int IDW     = 3;
    localparam int AW      = 5;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 12;
    localparam int W       = DW + IDW + 2;

    typedef struct {
        bit           qos;
        int           addr;
        logic [W-1:0] data;
    } wrExp_t;

    typedef struct {
        bit done;
        bit doneQos;
        bit err;
        int hC;
        int lC;
        int hD;
        int lD;
    } evExp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   passCount = 0;

    int             wp[2];
    int             cp[2];
    int             rp[2];
    int             dropCnt[2];
    bit             inPkt;
    int             curCls;
    int             curLen;
    logic [IDW-1:0] curId;
    wrExp_t         wrQ[$];
    evExp_t         evQ[$];

    always #5 clk = ~clk;

    qos_pkt_wr_ctrl_if #(.DW(DW), .IDW(IDW), .AW(AW)) busIf ();

    qos_pkt_wr_ctrl #(
        .DW(DW), .IDW(IDW), .AW(AW), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(busIf)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Packet-level reference: each class is a ring with a working and a committed end.
    task automatic modelBeat(input bit sop, input bit eop, input bit qos,
                             input logic [IDW-1:0] id, input logic [DW-1:0] data);
        bit     done, doneQos;
        bit     ab[2];
        int     a, n;
        wrExp_t w;
        evExp_t e;
        done = 0; doneQos = 0; ab[0] = 0; ab[1] = 0;
        if (sop) begin
            if (inPkt) begin
                ab[curCls] = 1; wp[curCls] = cp[curCls]; inPkt = 0;
            end
            a = wp[qos]; n = (a + 1) % DEPTH;
            if (n == rp[qos]) begin
                ab[qos] = 1; wp[qos] = cp[qos];
            end else begin
                w.qos = qos; w.addr = a; w.data = {1'b1, eop, id, data};
                wrQ.push_back(w);
                wp[qos] = n;
                if (eop) begin
                    cp[qos] = n; done = 1; doneQos = qos;
                end else begin
                    inPkt = 1; curCls = int'(qos); curId = id; curLen = 1;
                end
            end
        end else if (inPkt) begin
            a = wp[curCls]; n = (a + 1) % DEPTH;
            if ((!eop && curLen == MAX_LEN) || n == rp[curCls]) begin
                ab[curCls] = 1; wp[curCls] = cp[curCls]; inPkt = 0;
            end else begin
                w.qos = curCls[0]; w.addr = a; w.data = {1'b0, eop, curId, data};
                wrQ.push_back(w);
                wp[curCls] = n;
                if (eop) begin
                    cp[curCls] = n; done = 1; doneQos = curCls[0]; inPkt = 0;
                end else curLen++;
            end
        end
`ifdef QPWC_DROP_CNT_EN
        for (int c = 0; c < 2; c++)
            if (ab[c] && dropCnt[c] < 65535) dropCnt[c]++;
`endif
        if (done || ab[0] || ab[1]) begin
            e.done = done; e.doneQos = doneQos; e.err = ab[0] | ab[1];
            e.hC = cp[1]; e.lC = cp[0]; e.hD = dropCnt[1]; e.lD = dropCnt[0];
            evQ.push_back(e);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            wp[c] = 0; cp[c] = 0; dropCnt[c] = 0;
        end
        inPkt = 0; curCls = 0; curLen = 0; curId = '0;
        wrQ.delete();
        evQ.delete();
    endtask

    task automatic applyStimulus(input bit vld, input bit sop, input bit eop, input bit qos,
                                 input logic [IDW-1:0] id, input logic [DW-1:0] data);
        busIf.in_vld = vld; busIf.in_sop = sop; busIf.in_eop = eop;
        busIf.in_qos = qos; busIf.in_id = id; busIf.in_data = data;
        if (vld) modelBeat(sop, eop, qos, id, data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic setRaddr(input int h, input int l);
        rp[1] = h; rp[0] = l;
        busIf.hram_raddr = AW'(h);
        busIf.lram_raddr = AW'(l);
    endtask

    // Beats after the first carry random qos/id, which the DUT must ignore.
    task automatic sendPacket(input bit qos, input logic [IDW-1:0] id, input int len, input bit withEop);
        for (int i = 0; i < len; i++)
            applyStimulus(1'b1, i == 0, withEop && (i == len - 1),
                          (i == 0) ? qos : 1'($urandom_range(0, 1)),
                          (i == 0) ? id : IDW'($urandom), DW'($urandom));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " wen"}, {busIf.hram_wen, busIf.lram_wen}, 0);
        checkOutput({tag, " waddr"}, {busIf.hram_waddr, busIf.lram_waddr}, 0);
        checkOutput({tag, " wdata"}, {busIf.hram_wdata, busIf.lram_wdata}, 0);
        checkOutput({tag, " commit ptrs"}, {busIf.h_commit_ptr, busIf.l_commit_ptr}, 0);
        checkOutput({tag, " pulses"}, {busIf.pkt_done, busIf.pkt_done_qos, busIf.pkt_err}, 0);
        checkOutput({tag, " drop cnts"}, {busIf.h_drop_cnt, busIf.l_drop_cnt}, 0);
    endtask

    always @(negedge clk) begin : monitor
        wrExp_t          we;
        evExp_t          ee;
        logic [AW-1:0]   gotAddr;
        logic [W-1:0]    gotData;
        if (rst_n) begin
            if (busIf.hram_wen || busIf.lram_wen) begin
                if (wrQ.size() == 0) checkOutput("unexpected write", 1, 0);
                else begin
                    we = wrQ.pop_front();
                    gotAddr = busIf.hram_wen ? busIf.hram_waddr : busIf.lram_waddr;
                    gotData = busIf.hram_wen ? busIf.hram_wdata : busIf.lram_wdata;
                    checkOutput("write class {h,l}", {busIf.hram_wen, busIf.lram_wen}, we.qos ? 2 : 1);
                    checkOutput("write addr", gotAddr, we.addr);
                    checkOutput("write data", gotData, we.data);
                end
            end
            if (busIf.pkt_done || busIf.pkt_err) begin
                if (evQ.size() == 0) checkOutput("unexpected pkt event", 1, 0);
                else begin
                    ee = evQ.pop_front();
                    checkOutput("pkt_done", busIf.pkt_done, ee.done);
                    checkOutput("pkt_err", busIf.pkt_err, ee.err);
                    if (ee.done) checkOutput("pkt_done_qos", busIf.pkt_done_qos, ee.doneQos);
                    checkOutput("h_commit_ptr", busIf.h_commit_ptr, ee.hC);
                    checkOutput("l_commit_ptr", busIf.l_commit_ptr, ee.lC);
                    checkOutput("h_drop_cnt", busIf.h_drop_cnt, ee.hD);
                    checkOutput("l_drop_cnt", busIf.l_drop_cnt, ee.lD);
                end
            end
        end
    end

    initial begin
        int r;
        busIf.in_vld = 0; busIf.in_sop = 0; busIf.in_eop = 0;
        busIf.in_qos = 0; busIf.in_id = '0; busIf.in_data = '0;
        rp[0] = 0; rp[1] = 0;
        setRaddr(0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("power-on");
        rst_n = 1'b1;
        idle(2);

        // Low 4-beat packet, id 5.
        sendPacket(1'b0, 3'd5, 4, 1'b1);
        idle(3);
        checkOutput("low 4-beat l_commit_ptr", busIf.l_commit_ptr, 4);

        // High 6 then 10 beats with reader at 0: second packet hits full at address 15.
        sendPacket(1'b1, 3'd2, 6, 1'b1);
        sendPacket(1'b1, 3'd3, 10, 1'b1);
        idle(3);
        checkOutput("full abort h_commit_ptr", busIf.h_commit_ptr, 6);
`ifdef QPWC_DROP_CNT_EN
        checkOutput("full abort h_drop_cnt", busIf.h_drop_cnt, 1);
`else
        checkOutput("full abort h_drop_cnt", busIf.h_drop_cnt, 0);
`endif

        // Overlength packet, dropped tail, then a 2-beat packet reusing the addresses.
        setRaddr(0, 3);
        sendPacket(1'b0, 3'd1, MAX_LEN + 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h11);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h22);
        sendPacket(1'b0, 3'd4, 2, 1'b1);
        idle(3);
        checkOutput("overlength l_commit_ptr", busIf.l_commit_ptr, 6);

        // Bring the low ring to 14 and wrap a 3-beat packet across the end.
        sendPacket(1'b0, 3'd6, 8, 1'b1);
        setRaddr(0, 10);
        sendPacket(1'b0, 3'd2, 3, 1'b1);
        idle(3);
        checkOutput("wrap l_commit_ptr", busIf.l_commit_ptr, 1);

        // Mid-packet restart into the other class, then into the same class.
        sendPacket(1'b1, 3'd3, 3, 1'b0);
        sendPacket(1'b0, 3'd5, 2, 1'b1);
        idle(3);
        checkOutput("cross restart h_commit_ptr", busIf.h_commit_ptr, 6);
        checkOutput("cross restart l_commit_ptr", busIf.l_commit_ptr, 3);
        sendPacket(1'b1, 3'd1, 3, 1'b0);
        sendPacket(1'b1, 3'd2, 2, 1'b1);
        idle(3);
        checkOutput("same restart h_commit_ptr", busIf.h_commit_ptr, 8);

        // Reset in the middle of a packet.
        sendPacket(1'b1, 3'd4, 3, 1'b0);
        busIf.in_vld = 0;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResetState("mid-packet reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h5A);
        sendPacket(1'b1, 3'd6, 3, 1'b1);
        idle(3);
        checkOutput("after reset h_commit_ptr", busIf.h_commit_ptr, 3);

        // Randomized traffic with moving reader pointers.
        for (int p = 0; p < 300; p++) begin
            r = $urandom_range(0, 99);
            if (r < 8) setRaddr(rp[1], $urandom_range(0, DEPTH - 1));
            else if (r < 16) setRaddr($urandom_range(0, DEPTH - 1), rp[0]);
            else if (r < 30) setRaddr(cp[1], cp[0]);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), IDW'($urandom), DW'($urandom));
            sendPacket(1'($urandom_range(0, 1)), IDW'($urandom), $urandom_range(1, MAX_LEN + 3),
                       $urandom_range(0, 9) != 0);
        end
        idle(5);

        checkOutput("write queue drained", wrQ.size(), 0);
        checkOutput("event queue drained", evQ.size(), 0);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
